// File: rtl/cpu_pkg.sv
// Shared core types and constants: fetch FSM states, reset vector, NOP encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP            = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXEC,
    S_TRAP
  } fetch_state_t;

  // Clear the two low address bits so fetches stay word aligned.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(2'b11);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// PC register and single-outstanding instruction fetch sequencer.
// Optional INSTR_FETCH_MISALIGN_TRAP_EN: trap on misaligned next PC instead of aligning it.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_addr,
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  output logic            fetch_misaligned,
`endif
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            req_valid_q;

  logic [XLEN-1:0] resolve_pc_d;
  fetch_state_t    resolve_state_d;
  logic            resolve_trap_d;

  // Where the PC and FSM go when the current instruction resolves.
  always_comb begin
    resolve_pc_d    = pc_align(next_pc);
    resolve_state_d = S_REQ;
    resolve_trap_d  = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    if (next_pc[1:0] != 2'b00) begin
      resolve_pc_d    = next_pc;
      resolve_state_d = S_TRAP;
      resolve_trap_d  = 1'b1;
    end
`endif
  end

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign fetch_misaligned = misaligned_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= XLEN'(RESET_VECTOR);
      instr_q       <= INSTR_NOP;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        // Request stays low for the first cycle after reset, then holds until accepted.
        S_REQ: begin
          if (req_valid_q && imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            instr_q       <= imem_resp_data;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (next_pc_valid) begin
              pc_q        <= resolve_pc_d;
              state_q     <= resolve_state_d;
              req_valid_q <= ~resolve_trap_d;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
              misaligned_q <= resolve_trap_d;
`endif
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (next_pc_valid) begin
            pc_q        <= resolve_pc_d;
            state_q     <= resolve_state_d;
            req_valid_q <= ~resolve_trap_d;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            misaligned_q <= resolve_trap_d;
`endif
          end
        end
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          req_valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q       <= S_REQ;
          req_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_addr     = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch; also covers INSTR_FETCH_MISALIGN_TRAP_EN builds.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        next_pc_valid = 1'b0;
  logic [31:0] next_pc = 32'h0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int proto_viol = 0;
  bit tb_wait_resp = 1'b0;

  logic [31:0] exp_addr_q[$];
  sb_item_t    exp_instr_q[$];

  instr_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_addr      (instr_addr),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .next_pc_valid   (next_pc_valid),
    .next_pc         (next_pc)
  );

  always #5 clk = ~clk;

  // next_pc_valid while a fetch is pending is a protocol violation.
  always @(posedge clk) begin
    if (!reset && next_pc_valid && (imem_req_valid || tb_wait_resp)) proto_viol++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Accept one fetch request and answer it after lat cycles.
  task automatic do_request(input logic [31:0] data, input int lat, input bit inject);
    int n;
    logic [31:0] ea;
    sb_item_t it;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(imem_req_valid), 32'd1);
    check_eq("sb_addr_nonempty", 32'(exp_addr_q.size() > 0), 32'd1);
    ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
    check_eq("req_addr", imem_req_addr, ea);
    check_eq("req_instr_addr", instr_addr, ea);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    tb_wait_resp   = 1'b1;
    check_eq("req_drop", 32'(imem_req_valid), 32'd0);
    for (int i = 1; i < lat; i++) begin
      if (inject && i == 1) begin
        next_pc_valid = 1'b1;
        next_pc       = 32'hDEAD_BEE0;
      end
      @(negedge clk);
      next_pc_valid = 1'b0;
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    it.addr = ea;
    it.data = data;
    exp_instr_q.push_back(it);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    tb_wait_resp    = 1'b0;
  endtask

  // Take the instruction at decode, stall hold cycles, then resolve to npc.
  task automatic accept(input int hold, input bit same, input logic [31:0] npc);
    int n;
    bit trap;
    sb_item_t exp;
    trap = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    trap = (npc[1:0] != 2'b00);
`endif
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("instr_valid_seen", 32'(instr_valid), 32'd1);
    check_eq("sb_instr_nonempty", 32'(exp_instr_q.size() > 0), 32'd1);
    exp = (exp_instr_q.size() > 0) ? exp_instr_q.pop_front() : 64'hx;
    check_eq("instr", instr, exp.data);
    check_eq("instr_addr", instr_addr, exp.addr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(instr_valid), 32'd1);
      check_eq("hold_instr", instr, exp.data);
      check_eq("hold_addr", instr_addr, exp.addr);
      check_eq("hold_noreq", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    if (same) begin
      next_pc_valid = 1'b1;
      next_pc       = npc;
    end
    @(negedge clk);
    instr_ready = 1'b0;
    if (!same) begin
      check_eq("exec_valid_low", 32'(instr_valid), 32'd0);
      next_pc_valid = 1'b1;
      next_pc       = npc;
      @(negedge clk);
    end
    next_pc_valid = 1'b0;
    if (trap) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      check_eq("trap_flag", 32'(fetch_misaligned), 32'd1);
`endif
      check_eq("trap_noreq", 32'(imem_req_valid), 32'd0);
    end else begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      exp_addr_q.push_back(npc);
`else
      exp_addr_q.push_back(npc & 32'hFFFF_FFFC);
`endif
      check_eq("req_after_resolve", 32'(imem_req_valid), 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_instr_addr", instr_addr, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
    reset = 1'b0;
    exp_addr_q.push_back(32'h0);

    // First fetch: request in cycle 1, instruction in cycle 3.
    @(negedge clk);
    check_eq("cyc1_req_valid", 32'(imem_req_valid), 32'd1);
    do_request(32'h0050_0093, 1, 1'b0);
    check_eq("cyc3_instr_valid", 32'(instr_valid), 32'd1);
    accept(5, 1'b0, 32'h0000_0004);

    do_request(32'h0000_0004 ^ 32'h1357_9BDF, 2, 1'b0);
    accept(0, 1'b0, 32'h0000_0100);
    do_request(32'h0000_0100 ^ 32'h1357_9BDF, 1, 1'b0);
    accept(2, 1'b0, 32'hFFFF_FFFC);
    do_request(32'hFFFF_FFFC ^ 32'h1357_9BDF, 1, 1'b0);
    accept(0, 1'b0, 32'h0000_0000);
    do_request(32'h0000_0000 ^ 32'h1357_9BDF, 1, 1'b0);
    accept(0, 1'b1, 32'h0000_0008);

    // Stray next_pc while waiting for memory must be ignored.
    do_request(32'h0000_0008 ^ 32'h1357_9BDF, 3, 1'b1);
    check_eq("proto_flag", 32'(proto_viol), 32'd1);
    accept(1, 1'b1, 32'h0000_0020);

    // Reset while waiting for memory; the late response is dropped.
    check_eq("mid_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("mid_req_addr", imem_req_addr, 32'h0000_0020);
    void'(exp_addr_q.pop_front());
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check_eq("mid_req_reissue", 32'(imem_req_valid), 32'd1);
    check_eq("mid_req_addr_rv", imem_req_addr, 32'h0);
    check_eq("mid_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("mid_instr_nop", instr, 32'h0000_0013);
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(32'h0);
    do_request(32'h0000_0513, 1, 1'b0);
    accept(0, 1'b0, 32'h0000_0102);

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    repeat (6) begin
      @(negedge clk);
      check_eq("trap_hold_noreq", 32'(imem_req_valid), 32'd0);
      check_eq("trap_hold_flag", 32'(fetch_misaligned), 32'd1);
      check_eq("trap_pc", instr_addr, 32'h0000_0102);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("trap_rst_flag", 32'(fetch_misaligned), 32'd0);
    exp_addr_q.delete();
    exp_addr_q.push_back(32'h0);
    do_request(32'h0000_0613, 1, 1'b0);
    accept(0, 1'b1, 32'h0000_0004);
`else
    do_request(32'h0000_0100 ^ 32'h2468_ACE0, 1, 1'b0);
    accept(0, 1'b1, 32'h0000_0107);
    do_request(32'h0000_0104 ^ 32'h2468_ACE0, 2, 1'b0);
    accept(0, 1'b0, 32'h0000_0200);
`endif

    check_eq("sb_instr_empty", 32'(exp_instr_q.size()), 32'd0);
    check_eq("proto_total", 32'(proto_viol), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
